// File: rtl/parking_pkg.sv
// Shared encodings for the barrier-sensor emulator: command ops, FSM states
// and the {a,b} phase pattern for each op.
package parking_pkg;

   typedef enum logic [1:0] {
      OP_ENTER    = 2'b00,
      OP_EXIT     = 2'b01,
      OP_BALK_IN  = 2'b10,
      OP_BALK_OUT = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PH1,
      ST_PH2,
      ST_PH3,
      ST_PH4
   } state_t;

   localparam int unsigned TIMER_W = 8;

   // Four {a,b} phases packed MSB-first: phase 1 in [7:6], phase 4 in [1:0].
   localparam logic [7:0] PAT_ENTER    = 8'b10_11_01_00;
   localparam logic [7:0] PAT_EXIT     = 8'b01_11_10_00;
   localparam logic [7:0] PAT_BALK_IN  = 8'b10_11_10_00;
   localparam logic [7:0] PAT_BALK_OUT = 8'b01_11_01_00;

   function automatic logic [1:0] phase_bits(input op_t op, input logic [1:0] idx);
      logic [7:0] pat;
      logic [1:0] bits;
      case (op)
         OP_ENTER:   pat = PAT_ENTER;
         OP_EXIT:    pat = PAT_EXIT;
         OP_BALK_IN: pat = PAT_BALK_IN;
         default:    pat = PAT_BALK_OUT;
      endcase
      case (idx)
         2'd0:    bits = pat[7:6];
         2'd1:    bits = pat[5:4];
         2'd2:    bits = pat[3:2];
         default: bits = pat[1:0];
      endcase
      return bits;
   endfunction

endpackage

// File: rtl/parking_hold_timer.sv
// Phase dwell down-counter: load reloads the count, expired flags zero.
module parking_hold_timer
   import parking_pkg::*;
#(
   parameter int unsigned W = TIMER_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/parking_sensor_gen.sv
// Emulates the outer/inner barrier sensors for one car pass per command and
// tracks the count the lot counter should report after each sequence.
module parking_sensor_gen
   import parking_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter int unsigned COUNT_W     = 3,
   parameter int unsigned MAX_COUNT   = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   input  logic [1:0]         cmd_op,
   output logic               cmd_ready,
   output logic               a,
   output logic               b,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] exp_count
);

   localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [COUNT_W-1:0] MAX_C     = COUNT_W'(MAX_COUNT);

   state_t             r_state;
   op_t                r_op;
   logic               r_a;
   logic               r_b;
   logic               r_busy;
   logic               r_done;
   logic [COUNT_W-1:0] r_exp_count;

   logic               w_accept;
   logic               w_expired;
   logic               w_load;
   op_t                w_cmd_op;

   assign w_cmd_op  = op_t'(cmd_op);
   assign cmd_ready = (r_state == ST_IDLE);
   assign w_accept  = cmd_ready && cmd_valid;
   // Reload on accept and on every phase change so each phase gets a full dwell.
   assign w_load    = w_accept || ((r_state != ST_IDLE) && w_expired);

   parking_hold_timer #(
      .W(TIMER_W)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load),
      .i_load_val(HOLD_LOAD),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_ENTER;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_exp_count <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_op         <= w_cmd_op;
                  r_state      <= ST_PH1;
                  {r_a, r_b}   <= phase_bits(w_cmd_op, 2'd0);
                  r_busy       <= 1'b1;
               end
            end
            ST_PH1: begin
               if (w_expired) begin
                  r_state    <= ST_PH2;
                  {r_a, r_b} <= phase_bits(r_op, 2'd1);
               end
            end
            ST_PH2: begin
               if (w_expired) begin
                  r_state    <= ST_PH3;
                  {r_a, r_b} <= phase_bits(r_op, 2'd2);
               end
            end
            ST_PH3: begin
               if (w_expired) begin
                  r_state    <= ST_PH4;
                  {r_a, r_b} <= phase_bits(r_op, 2'd3);
               end
            end
            ST_PH4: begin
               if (w_expired) begin
                  r_state    <= ST_IDLE;
                  {r_a, r_b} <= 2'b00;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  case (r_op)
                     OP_ENTER: if (r_exp_count < MAX_C) r_exp_count <= r_exp_count + 1'b1;
                     OP_EXIT:  if (r_exp_count != '0)   r_exp_count <= r_exp_count - 1'b1;
                     default:  r_exp_count <= r_exp_count;
                  endcase
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign a         = r_a;
   assign b         = r_b;
   assign busy      = r_busy;
   assign done      = r_done;
   assign exp_count = r_exp_count;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Directed bench: one instance with 1-cycle phases, one with 3-cycle phases.
module tb_parking_sensor_gen;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;

   logic       v1  = 1'b0;
   logic [1:0] op1 = 2'b00;
   logic       rdy1, a1, b1, busy1, done1;
   logic [2:0] cnt1;

   logic       v3  = 1'b0;
   logic [1:0] op3 = 2'b00;
   logic       rdy3, a3, b3, busy3, done3;
   logic [2:0] cnt3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   parking_sensor_gen #(.HOLD_CYCLES(1), .COUNT_W(3), .MAX_COUNT(7)) dut1 (
      .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_op(op1), .cmd_ready(rdy1),
      .a(a1), .b(b1), .busy(busy1), .done(done1), .exp_count(cnt1)
   );

   parking_sensor_gen #(.HOLD_CYCLES(3), .COUNT_W(3), .MAX_COUNT(7)) dut3 (
      .clk(clk), .reset(reset), .cmd_valid(v3), .cmd_op(op3), .cmd_ready(rdy3),
      .a(a3), .b(b3), .busy(busy3), .done(done3), .exp_count(cnt3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for idle, presents a command for one accept edge.
   task automatic issue(input bit sel3, input logic [1:0] op);
      int n = 0;
      while (!(sel3 ? rdy3 : rdy1) && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (!(sel3 ? rdy3 : rdy1)) begin
         bad++;
         $display("FAIL ready_timeout: cmd_ready=0 after %0d cycles, want 1", n);
      end
      if (sel3) begin v3 = 1'b1; op3 = op; end
      else      begin v1 = 1'b1; op1 = op; end
      tick();
      v1 = 1'b0;
      v3 = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      tick();
      tick();
      total++;
      if ({a1, b1, busy1, done1, cnt1, rdy1} !== {4'b0000, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset_h1: a=%b b=%b busy=%b done=%b cnt=%0d rdy=%b want 0 0 0 0 0 1",
                  a1, b1, busy1, done1, cnt1, rdy1);
      end
      total++;
      if ({a3, b3, busy3, done3, cnt3, rdy3} !== {4'b0000, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset_h3: a=%b b=%b busy=%b done=%b cnt=%0d rdy=%b want 0 0 0 0 0 1",
                  a3, b3, busy3, done3, cnt3, rdy3);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_enter();
      logic [1:0] pat [4];
      pat = '{2'b10, 2'b11, 2'b01, 2'b00};
      issue(1'b0, 2'b00);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({a1, b1} !== pat[i] || busy1 !== 1'b1 || done1 !== 1'b0) begin
            bad++;
            $display("FAIL enter_ph%0d: ab=%b busy=%b done=%b want ab=%b busy=1 done=0",
                     i, {a1, b1}, busy1, done1, pat[i]);
         end
         tick();
      end
      total++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 3'd1 || {a1, b1} !== 2'b00) begin
         bad++;
         $display("FAIL enter_done: done=%b busy=%b cnt=%0d ab=%b want 1 0 1 00",
                  done1, busy1, cnt1, {a1, b1});
      end
      tick();
      total++;
      if (done1 !== 1'b0) begin
         bad++;
         $display("FAIL enter_done_pulse: done=%b want 0", done1);
      end
   endtask

   task automatic test_exit_floor();
      logic [1:0] pat [4];
      pat = '{2'b01, 2'b11, 2'b10, 2'b00};
      for (int r = 0; r < 2; r++) begin
         issue(1'b0, 2'b01);
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({a1, b1} !== pat[i] || busy1 !== 1'b1) begin
               bad++;
               $display("FAIL exit%0d_ph%0d: ab=%b busy=%b want ab=%b busy=1",
                        r, i, {a1, b1}, busy1, pat[i]);
            end
            tick();
         end
         total++;
         if (done1 !== 1'b1 || cnt1 !== 3'd0) begin
            bad++;
            $display("FAIL exit%0d_done: done=%b cnt=%0d want 1 0", r, done1, cnt1);
         end
      end
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 8; k++) begin
         issue(1'b0, 2'b00);
         repeat (4) tick();
         total++;
         if (done1 !== 1'b1 || cnt1 !== ((k < 7) ? 3'(k + 1) : 3'd7)) begin
            bad++;
            $display("FAIL sat_enter%0d: done=%b cnt=%0d want 1 %0d",
                     k, done1, cnt1, (k < 7) ? k + 1 : 7);
         end
      end
   endtask

   task automatic test_balk();
      logic [1:0] pat [2][4];
      pat[0] = '{2'b10, 2'b11, 2'b10, 2'b00};
      pat[1] = '{2'b01, 2'b11, 2'b01, 2'b00};
      for (int k = 0; k < 4; k++) begin
         issue(1'b0, 2'b01);
         repeat (4) tick();
         total++;
         if (cnt1 !== 3'(6 - k)) begin
            bad++;
            $display("FAIL balk_setup%0d: cnt=%0d want %0d", k, cnt1, 6 - k);
         end
      end
      for (int s = 0; s < 2; s++) begin
         issue(1'b0, (s == 0) ? 2'b10 : 2'b11);
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({a1, b1} !== pat[s][i] || busy1 !== 1'b1) begin
               bad++;
               $display("FAIL balk%0d_ph%0d: ab=%b busy=%b want ab=%b busy=1",
                        s, i, {a1, b1}, busy1, pat[s][i]);
            end
            tick();
         end
         total++;
         if (done1 !== 1'b1 || cnt1 !== 3'd3) begin
            bad++;
            $display("FAIL balk%0d_done: done=%b cnt=%0d want 1 3", s, done1, cnt1);
         end
      end
   endtask

   task automatic test_hold3();
      logic [1:0] pat [4];
      pat = '{2'b10, 2'b11, 2'b01, 2'b00};
      issue(1'b1, 2'b00);
      for (int i = 0; i < 12; i++) begin
         total++;
         if ({a3, b3} !== pat[i / 3] || busy3 !== 1'b1 || done3 !== 1'b0) begin
            bad++;
            $display("FAIL hold3_cyc%0d: ab=%b busy=%b done=%b want ab=%b busy=1 done=0",
                     i, {a3, b3}, busy3, done3, pat[i / 3]);
         end
         if (i == 4) begin v3 = 1'b1; op3 = 2'b01; end
         if (i == 5) v3 = 1'b0;
         tick();
      end
      total++;
      if (done3 !== 1'b1 || busy3 !== 1'b0 || cnt3 !== 3'd1) begin
         bad++;
         $display("FAIL hold3_done: done=%b busy=%b cnt=%0d want 1 0 1", done3, busy3, cnt3);
      end
      repeat (8) tick();
      total++;
      if (busy3 !== 1'b0 || done3 !== 1'b0 || cnt3 !== 3'd1) begin
         bad++;
         $display("FAIL hold3_ignored: busy=%b done=%b cnt=%0d want 0 0 1", busy3, done3, cnt3);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] pat [4];
      pat = '{2'b10, 2'b11, 2'b01, 2'b00};
      v1  = 1'b1;
      op1 = 2'b00;
      tick();
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({a1, b1} !== pat[i] || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_ph%0d: ab=%b busy=%b want ab=%b busy=1",
                     i, {a1, b1}, busy1, pat[i]);
         end
         tick();
      end
      total++;
      if (done1 !== 1'b1 || cnt1 !== 3'd4 || rdy1 !== 1'b1 || {a1, b1} !== 2'b00) begin
         bad++;
         $display("FAIL b2b_mid: done=%b cnt=%0d rdy=%b ab=%b want 1 4 1 00",
                  done1, cnt1, rdy1, {a1, b1});
      end
      tick();
      v1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({a1, b1} !== pat[i] || busy1 !== 1'b1 || done1 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_ph%0d: ab=%b busy=%b done=%b want ab=%b busy=1 done=0",
                     i, {a1, b1}, busy1, done1, pat[i]);
         end
         tick();
      end
      total++;
      if (done1 !== 1'b1 || cnt1 !== 3'd5) begin
         bad++;
         $display("FAIL b2b_done: done=%b cnt=%0d want 1 5", done1, cnt1);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] pat [4];
      pat = '{2'b10, 2'b11, 2'b01, 2'b00};
      issue(1'b0, 2'b00);
      tick();
      total++;
      if ({a1, b1} !== 2'b11) begin
         bad++;
         $display("FAIL rstmid_ph2: ab=%b want 11", {a1, b1});
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({a1, b1, busy1, done1, cnt1, rdy1} !== {4'b0000, 3'd0, 1'b1}) begin
         bad++;
         $display("FAIL rstmid_async: a=%b b=%b busy=%b done=%b cnt=%0d rdy=%b want 0 0 0 0 0 1",
                  a1, b1, busy1, done1, cnt1, rdy1);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (done1 !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 3'd0) begin
            bad++;
            $display("FAIL rstmid_quiet%0d: done=%b busy=%b cnt=%0d want 0 0 0",
                     i, done1, busy1, cnt1);
         end
      end
      issue(1'b0, 2'b00);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({a1, b1} !== pat[i] || busy1 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_after_ph%0d: ab=%b busy=%b want ab=%b busy=1",
                     i, {a1, b1}, busy1, pat[i]);
         end
         tick();
      end
      total++;
      if (done1 !== 1'b1 || cnt1 !== 3'd1) begin
         bad++;
         $display("FAIL rstmid_after_done: done=%b cnt=%0d want 1 1", done1, cnt1);
      end
   endtask

   initial begin
      test_reset();
      test_enter();
      test_exit_floor();
      test_saturate();
      test_balk();
      test_hold3();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
